instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the arvi core. It sits directly upstream of the main decode/control block. It owns the fetch PC, issues one-outstanding-request reads on the instruction bus, and buffers returned words in a small prefetch FIFO. It presents {instruction, PC, fault} to decode, honouring the decode stall and redirecting on branches, jumps and traps.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; legal values 2 or 4.
- i_clk  in  1  core clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_Stall  in  1  decode cannot accept the head entry this cycle.
- i_Redirect  in  1  flush and restart fetch at i_Redirect_PC (branch taken, jump, trap, mret).
- i_Redirect_PC  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- o_IBus_req  out  1  read request, registered.
- o_IBus_addr  out  32  word-aligned read address, registered.
- i_IBus_ack  in  1  request completes this cycle; ignored when o_IBus_req=0.
- i_IBus_rdata  in  32  read data, valid with i_IBus_ack.
- i_IBus_err  in  1  access fault, valid with i_IBus_ack.
- o_Instr  out  32  head instruction; 32'h0000_0013 (NOP) when o_Valid=0.
- o_PC  out  32  PC of the head instruction.
- o_Valid  out  1  head entry present.
- o_Fetch_err  out  1  head entry carries an access fault; o_Instr is NOP.

## Operation
- State: fetch PC fpc; FIFO of {pc, instr, err}; count; FSM in IDLE, REQ, DRAIN or HALT.
- IDLE: o_IBus_req=0. Go to REQ and drive o_IBus_addr=fpc when count < FIFO_DEPTH.
- REQ: o_IBus_req=1. o_IBus_addr stays stable until i_IBus_ack. On ack:
  - Push {fpc, rdata, err} and set fpc += 4 (mod 2^32, wraps silently).
  - If err, go to HALT.
  - Otherwise, if count after push/pop < FIFO_DEPTH, stay in REQ with the new address (no bubble). Else go to IDLE.
- DRAIN: entered when a redirect arrives while in REQ without ack that cycle. The bus rule forbids dropping req before ack, so req and addr stay held. On ack, discard the response and go to REQ at the saved target.
- HALT: no requests. Leave only on i_Redirect.
- Pop: the head is removed when o_Valid=1 and i_Stall=0 and i_Redirect=0.
- Redirect priority: i_Redirect outranks pop and push in the same cycle.
  - FIFO flushes; count becomes 0 next cycle.
  - fpc takes {i_Redirect_PC[31:2],2'b00}.
  - From REQ with an ack the same cycle, the response is dropped and the FSM goes to REQ at the target next cycle.
  - From REQ without an ack, the FSM goes to DRAIN.
  - From IDLE or HALT, the FSM goes to REQ.
  - From DRAIN, the saved target is overwritten by the newest redirect.
- Issue rule: a request is issued only if a slot is guaranteed (count + outstanding ≤ FIFO_DEPTH). Overflow is therefore impossible.
- Empty FIFO outputs: o_Instr=NOP, o_Fetch_err=0, o_PC equal to the last head PC. Decode thus sees no spurious illegal-opcode exception.
- Faulted entry: o_Fetch_err=1 and o_Instr=NOP. Decode/trap logic raises the fault, and the resulting redirect leaves HALT.

## Timing
- Reset values: o_IBus_req=0, o_IBus_addr=RESET_PC, o_Valid=0, o_Instr=32'h0000_0013, o_PC=RESET_PC, o_Fetch_err=0. Also fpc=RESET_PC, count=0, FSM in IDLE.
- Reset mid-transaction: req drops at the reset edge and any in-flight response is never captured. The bus shares i_rst.
- Reset release at edge E0 gives req=1 in cycle 1. An ack in cycle k makes o_Valid=1 in cycle k+1.
- Single-cycle-ack memory with i_Stall=0 sustains 1 instruction/cycle.
- Redirect at edge R: o_Valid=0 in cycle R+1. Zero-wait memory gives the first target instruction valid at R+2 (from IDLE) or R+ack+2 (from DRAIN).
- Outputs are registered or FIFO-head-from-registers; there are no combinational paths from bus inputs to decode outputs.

## Test plan
- Reset, RESET_PC=0, memory acks every cycle with rdata=addr|0x13, i_Stall=0 -> req in cycle 1; o_Valid from cycle 2; o_PC = 0, 4, 8… on consecutive cycles.
- i_Stall=1 for 5 cycles with DEPTH=2 -> exactly 2 words buffered, req low while full, o_PC held. Releasing the stall resumes in-order delivery with no duplicate or lost PC.
- Redirect to 0x100 while a request to 0x8 waits 3 cycles for ack -> addr 0x8 held until ack, its data discarded, next request addr=0x100, first o_PC=0x100.
- Redirect concurrent with ack and with a pop -> neither the pop nor the acked word is delivered; next o_PC equals the target. Target 0x103 -> fetch at 0x100.
- i_IBus_err on the fetch at 0x20 -> head shows o_Fetch_err=1, o_Instr=NOP, o_PC=0x20, with no further requests. Redirect to 0x40 resumes fetch.
- fpc=0xFFFF_FFFC -> next fetch address 0x0000_0000. Asserting i_rst mid-request -> req low next cycle and all reset values restored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata,
        output err
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one bus read in
// flight and buffers returned words in a small prefetch FIFO for decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_Stall,
    input  logic                i_Redirect,
    input  logic [31:0]         i_Redirect_PC,
    instr_fetch_if.master       ibus,
    output logic [31:0]         o_Instr,
    output logic [31:0]         o_PC,
    output logic                o_Valid,
    output logic                o_Fetch_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    state_t             state;
    logic [31:0]        fpc;
    logic [31:0]        last_pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    entry_t             fifo_q [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   cnt_next;
    logic [31:0]        redir_pc;
    logic [31:0]        fpc_inc;
    entry_t             head;

    // Handshake decode; a redirect beats both push and pop
    always_comb begin
        redir_pc = i_Redirect_PC & ~32'h0000_0003;
        fpc_inc  = fpc + 32'd4;
        push     = (state == REQ) && ibus.ack && !i_Redirect;
        pop      = o_Valid && !i_Stall && !i_Redirect;
        cnt_next = count;
        if (push && !pop) begin
            cnt_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_next = count - CNT_W'(1);
        end
    end

    // Prefetch storage; occupancy is tracked separately so no reset is needed
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc: fpc, instr: ibus.rdata, err: ibus.err};
        end
    end

    // FIFO pointers/occupancy; a redirect flushes everything
    always_ff @(posedge i_clk) begin
        if (i_rst || i_Redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= cnt_next;
        end
    end

    // Remember the most recent head PC so o_PC holds when the FIFO is empty
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_pc <= RESET_PC;
        end else if (o_Valid) begin
            last_pc <= head.pc;
        end
    end

    // Fetch FSM: fetch PC, bus request and address; during DRAIN fpc holds the target
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            ibus.req  <= 1'b0;
            ibus.addr <= RESET_PC;
        end else begin
            if (i_Redirect) begin
                fpc <= redir_pc;
            end else if (push) begin
                fpc <= fpc_inc;
            end

            case (state)
                IDLE: begin
                    if (i_Redirect) begin
                        state     <= REQ;
                        ibus.req  <= 1'b1;
                        ibus.addr <= redir_pc;
                    end else if (count < DEPTH_C) begin
                        state     <= REQ;
                        ibus.req  <= 1'b1;
                        ibus.addr <= fpc;
                    end
                end
                REQ: begin
                    if (i_Redirect) begin
                        if (ibus.ack) begin
                            ibus.addr <= redir_pc;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (ibus.ack) begin
                        if (ibus.err) begin
                            state    <= HALT;
                            ibus.req <= 1'b0;
                        end else if (cnt_next < DEPTH_C) begin
                            ibus.addr <= fpc_inc;
                        end else begin
                            state    <= IDLE;
                            ibus.req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (ibus.ack) begin
                        state     <= REQ;
                        ibus.addr <= i_Redirect ? redir_pc : fpc;
                    end
                end
                HALT: begin
                    if (i_Redirect) begin
                        state     <= REQ;
                        ibus.req  <= 1'b1;
                        ibus.addr <= redir_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ibus.req <= 1'b0;
                end
            endcase
        end
    end

    // Decode-facing view of the FIFO head; faulted or absent entries show NOP
    always_comb begin
        head        = fifo_q[rd_ptr];
        o_Valid     = (count != '0);
        o_Fetch_err = o_Valid && head.err;
        o_Instr     = (o_Valid && !head.err) ? head.instr : NOP;
        o_PC        = o_Valid ? head.pc : last_pc;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scripted zero-wait instruction memory.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fetch_err;

    logic        ack_en;
    logic [31:0] err_addr;
    int          checks;
    int          failures;

    instr_fetch_if ibus ();

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_Stall       (stall),
        .i_Redirect    (redirect),
        .i_Redirect_PC (redirect_pc),
        .ibus          (ibus.master),
        .o_Instr       (instr),
        .o_PC          (pc),
        .o_Valid       (valid),
        .o_Fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: each word encodes its own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) | 32'h0000_0013;
    endfunction

    // Memory response for the current cycle, from the registered request
    task automatic drive_mem();
        ibus.ack   = ack_en && ibus.req;
        ibus.rdata = ibus.ack ? mem_word(ibus.addr) : 32'h0;
        ibus.err   = ibus.ack && (ibus.addr == err_addr);
    endtask

    // Advance one clock; outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        drive_mem();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack_en      = 1'b1;
        err_addr    = 32'hDEAD_BEE0;
        ibus.ack    = 1'b0;
        ibus.rdata  = 32'h0;
        ibus.err    = 1'b0;

        // Reset values
        cyc();
        cyc();
        chk("rst_req",   32'(ibus.req), 32'd0);
        chk("rst_addr",  ibus.addr, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_ferr",  32'(fetch_err), 32'd0);

        // Release: request in cycle 1, data from cycle 2 at one per cycle
        rst = 1'b0;
        cyc();
        chk("c1_req",   32'(ibus.req), 32'd1);
        chk("c1_addr",  ibus.addr, 32'h0);
        chk("c1_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stream_valid", 32'(valid), 32'd1);
            chk("stream_pc",    pc, 32'(4 * i));
            chk("stream_instr", instr, mem_word(32'(4 * i)));
        end

        // Stall with depth 2: holds PC 12, buffers 16, request drops
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_pc",    pc, 32'h0C);
            chk("stall_req",   32'(ibus.req), 32'd0);
            chk("stall_valid", 32'(valid), 32'd1);
        end
        stall = 1'b0;
        cyc();
        chk("unstall_pc0",  pc, 32'h10);
        chk("unstall_req0", 32'(ibus.req), 32'd0);
        cyc();
        chk("unstall_empty", 32'(valid), 32'd0);
        chk("unstall_hold",  pc, 32'h10);
        chk("unstall_nop",   instr, NOP);
        chk("unstall_req1",  32'(ibus.req), 32'd1);
        chk("unstall_addr",  ibus.addr, 32'h14);
        cyc();
        chk("unstall_pc1",  pc, 32'h14);
        chk("unstall_ins1", instr, mem_word(32'h14));

        // Redirect while the request to 0x18 waits for its ack
        ack_en = 1'b0;
        drive_mem();
        cyc();
        chk("wait_valid", 32'(valid), 32'd0);
        chk("wait_addr",  ibus.addr, 32'h18);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        chk("drain_req",   32'(ibus.req), 32'd1);
        chk("drain_addr",  ibus.addr, 32'h18);
        chk("drain_valid", 32'(valid), 32'd0);
        cyc();
        chk("drain_addr2", ibus.addr, 32'h18);
        ack_en = 1'b1;
        drive_mem();
        cyc();
        chk("drain_target", ibus.addr, 32'h100);
        chk("drain_drop",   32'(valid), 32'd0);
        cyc();
        chk("tgt_pc",    pc, 32'h100);
        chk("tgt_instr", instr, mem_word(32'h100));

        // Redirect together with an ack and a would-be pop; target is unaligned
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        cyc();
        redirect = 1'b0;
        chk("rdack_valid", 32'(valid), 32'd0);
        chk("rdack_addr",  ibus.addr, 32'h200);
        chk("rdack_pc",    pc, 32'h100);
        cyc();
        chk("rdack_pc1", pc, 32'h200);

        // Access fault on 0x208: faulted head, then no more requests
        err_addr = 32'h208;
        cyc();
        chk("pre_err_pc", pc, 32'h204);
        cyc();
        chk("err_valid", 32'(valid), 32'd1);
        chk("err_pc",    pc, 32'h208);
        chk("err_flag",  32'(fetch_err), 32'd1);
        chk("err_instr", instr, NOP);
        chk("err_req",   32'(ibus.req), 32'd0);
        stall = 1'b1;
        cyc();
        chk("halt_req", 32'(ibus.req), 32'd0);
        cyc();
        chk("halt_req2", 32'(ibus.req), 32'd0);
        chk("halt_pc",   pc, 32'h208);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("resume_req",  32'(ibus.req), 32'd1);
        chk("resume_addr", ibus.addr, 32'h40);
        chk("resume_ferr", 32'(fetch_err), 32'd0);
        cyc();
        chk("resume_pc", pc, 32'h40);

        // Fetch address wraps past the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        chk("wrap_addr0", ibus.addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc",    pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        chk("wrap_addr1", ibus.addr, 32'h0);

        // Reset in the middle of an outstanding request
        ack_en = 1'b0;
        drive_mem();
        cyc();
        chk("mid_req", 32'(ibus.req), 32'd1);
        rst    = 1'b1;
        ack_en = 1'b1;
        drive_mem();
        cyc();
        chk("mrst_req",   32'(ibus.req), 32'd0);
        chk("mrst_addr",  ibus.addr, 32'h0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_instr", instr, NOP);
        chk("mrst_pc",    pc, 32'h0);
        chk("mrst_ferr",  32'(fetch_err), 32'd0);
        rst = 1'b0;
        cyc();
        chk("mrst_restart", 32'(ibus.req), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
